// File: rtl/div_32.sv
// div_32: 16-bit unsigned restoring divider, one quotient bit per clock.
// Takes 16 iteration cycles for a non-zero divisor. Divide-by-zero finishes
// immediately with Q = all ones, R = dividend and div0 set.
// Q, R and div0 hold the last result until the next one is ready.

module div_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

    state_t      r_state;
    logic [15:0] r_dividend;
    logic [15:0] r_divisor;
    logic [16:0] r_rem;
    logic [15:0] r_quot;
    logic [4:0]  r_cnt;

    logic [16:0] w_shift;
    logic        w_ge;
    logic [16:0] w_sub;
    logic [16:0] w_next_rem;
    logic [15:0] w_next_quot;

    // One restoring step. The bit shifted out of r_rem[16] takes part in the
    // compare, so no bit of the partial remainder is ever dropped.
    assign w_shift     = {r_rem[15:0], r_dividend[15]};
    assign w_ge        = r_rem[16] | (w_shift >= {1'b0, r_divisor});
    assign w_sub       = w_shift - {1'b0, r_divisor};
    assign w_next_rem  = w_ge ? w_sub : w_shift;
    assign w_next_quot = {r_quot[14:0], w_ge};

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_dividend <= 16'd0;
            r_divisor  <= 16'd0;
            r_rem      <= 17'd0;
            r_quot     <= 16'd0;
            r_cnt      <= 5'd0;
            Q          <= 16'd0;
            R          <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div0       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (init) begin
                        if (B == 16'd0) begin
                            Q       <= 16'hFFFF;
                            R       <= A;
                            div0    <= 1'b1;
                            done    <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_dividend <= A;
                            r_divisor  <= B;
                            r_rem      <= 17'd0;
                            r_quot     <= 16'd0;
                            r_cnt      <= 5'd16;
                            busy       <= 1'b1;
                            r_state    <= StIter;
                        end
                    end
                end
                StIter: begin
                    r_dividend <= {r_dividend[14:0], 1'b0};
                    r_rem      <= w_next_rem;
                    r_quot     <= w_next_quot;
                    r_cnt      <= r_cnt - 5'd1;
                    // Counter reaches zero on this edge: publish the result.
                    if (r_cnt == 5'd1) begin
                        Q       <= w_next_quot;
                        R       <= w_next_rem[15:0];
                        div0    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    // Held init never retriggers; wait for it to drop.
                    if (!init) begin
                        done    <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/div_32.md
DIV_32 -- requirements
Module: div_32

Interface
REQ-001 The block SHALL expose these ports, in this order:
- clk    in   1   sole clock; all state changes on its rising edge
- rst    in   1   asynchronous, active-low reset (0 = reset)
- init   in   1   start request, level-sampled
- A      in   16  dividend, unsigned
- B      in   16  divisor, unsigned
- Q      out  16  quotient, registered
- R      out  16  remainder, registered
- busy   out  1   high while iterating
- done   out  1   result valid
- div0   out  1   last operation had B == 0

REQ-002 The block SHALL have no parameters; width is fixed at 16/16 -> 16/16.

Function
REQ-003 The block SHALL contain one FSM with states IDLE, ITER and DONE.
REQ-004 In IDLE, a rising edge with init=1 and B!=0 SHALL:
- latch A into the dividend shift register;
- latch B into the divisor register;
- clear the 17-bit partial remainder and the quotient register;
- set the iteration counter to 16;
- move to ITER.
REQ-005 In IDLE, a rising edge with init=1 and B==0 SHALL:
- set Q=16'hFFFF, R=A and div0=1;
- move to DONE without iterating.
REQ-006 Each rising edge in ITER SHALL perform one restoring step:
- shift the partial remainder left one bit, bringing in the dividend MSB;
- shift the dividend left;
- if partial remainder >= divisor, subtract the divisor and shift 1 into the quotient LSB, else shift in 0;
- decrement the counter.
REQ-007 The comparison and subtraction SHALL use 17-bit unsigned arithmetic; no bit SHALL be lost at any intermediate step.
REQ-008 On the ITER edge where the counter reaches 0, the block SHALL load the final quotient into Q, the low 16 bits of the remainder into R, and div0=0, and move to DONE.
REQ-009 Latency SHALL be as follows, where the init-sampling edge is edge 0:
- B != 0: done rises after edge 16;
- B == 0: done rises after edge 0.
REQ-010 busy SHALL be 1 exactly while the state is ITER.
REQ-011 done SHALL be 1 exactly while the state is DONE.
REQ-012 init SHALL be ignored in ITER; A and B SHALL be don't-care after the init-sampling edge.
REQ-013 In DONE, the FSM SHALL return to IDLE on the first edge with init=0, and SHALL remain in DONE while init=1; a held init therefore never retriggers.
REQ-014 Q, R and div0 SHALL change only when entering DONE, and SHALL hold their values through IDLE and ITER until the next result.
REQ-015 For B != 0, results SHALL satisfy A == Q*B + R with R < B over the full unsigned range.

Reset
REQ-016 When rst=0, the block SHALL asynchronously force:
- state to IDLE;
- Q=0, R=0, busy=0, done=0, div0=0;
- counter and internal registers to 0.
REQ-017 Reset asserted mid-ITER SHALL abort the operation with no partial result visible on Q or R.
REQ-018 After rst is released, the first init sampled high in IDLE SHALL start a fresh operation.

Verification
REQ-019 A=100, B=7, init pulse of 1 cycle -> busy for 16 cycles; done after edge 16; Q=14, R=2, div0=0.
REQ-020 A=16'hFFFF, B=1 -> Q=16'hFFFF, R=0. A=16'hFFFF, B=16'hFFFF -> Q=1, R=0. A=3, B=10 -> Q=0, R=3.
REQ-021 A=5, B=0 -> done after edge 0, busy never high, Q=16'hFFFF, R=5, div0=1. A following A=9, B=2 run -> Q=4, R=1, div0=0.
REQ-022 init held high for 40 cycles with A=50, B=5 -> exactly one operation; Q=10, R=0; done stays high until init drops, then IDLE on the next edge.
REQ-023 rst=0 at the 8th ITER cycle -> all outputs 0 immediately. After release, A=1000, B=33 -> Q=30, R=10 after 16 cycles.
REQ-024 Random regression of at least 10k unsigned pairs, with B=0 included at about 1% -> the REQ-015 relation checked and the latency checked on every operation.
